// File: rtl/power_monitor_if.sv
// Avalon-MM slave bus bundle used by power_monitor_slave.
interface power_monitor_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect,
    output address,
    output write,
    output read,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  address,
    input  write,
    input  read,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/power_monitor_slave.sv
// Scans NUM_CH rail comparators through an external mux, latches debounced faults, drives kill_sw.
// Optional feature macro: POWER_MONITOR_IRQ_EN (adds irq output, CTRL b3 clear, STATUS b11).
module power_monitor_slave #(
  parameter int NUM_CH     = 8,
  parameter int SEL_W      = 3,
  parameter int SETTLE_CYC = 16,
  parameter int DEBOUNCE   = 4
) (
  input  logic             clk,
  input  logic             reset,
  power_monitor_if.slave   bus,
  input  logic             data,
  output logic [SEL_W-1:0] mux,
  output logic             kill_sw,
  output logic             error
`ifdef POWER_MONITOR_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int WIN   = SETTLE_CYC + DEBOUNCE;
  localparam int CNT_W = $clog2(WIN + 1);
  localparam int HIT_W = $clog2(DEBOUNCE + 1);

  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_END    = CNT_W'(WIN - 1);
  localparam logic [HIT_W-1:0] HIT_MAX    = HIT_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    NEXT
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [HIT_W-1:0]  hits_reg, hits_next;
  logic [HIT_W-1:0]  hits_inc;
  logic [SEL_W-1:0]  mux_next;
  logic              set_hit;

  logic              start_reg;
  logic              force_reg;
  logic [NUM_CH-1:0] fault_reg;
  logic [NUM_CH-1:0] mask_reg;
  logic [NUM_CH-1:0] fault_set;
  logic [NUM_CH-1:0] fault_clr;
  logic [NUM_CH-1:0] fault_next;
  logic [31:0]       rd_word;
  logic              busy;

  logic wr_en;
  logic rd_en;
  logic wr_ctrl;
  logic wr_fault;
  logic wr_mask;
  logic unused_wd;

  assign wr_en     = bus.chipselect & bus.write;
  assign rd_en     = bus.chipselect & bus.read;
  assign wr_ctrl   = wr_en && (bus.address == 2'd0);
  assign wr_fault  = wr_en && (bus.address == 2'd2);
  assign wr_mask   = wr_en && (bus.address == 2'd3);
  assign busy      = (state_reg != IDLE);
  assign unused_wd = ^bus.writedata;

  // Scan sequencer: one counter spans the settle and sample windows of a channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hits_reg  <= '0;
      mux       <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hits_reg  <= hits_next;
      mux       <= mux_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hits_next  = hits_reg;
    mux_next   = mux;
    hits_inc   = '0;
    set_hit    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_reg) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      SETTLE: begin
        if (!start_reg) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == SETTLE_END) begin
            state_next = SAMPLE;
            hits_next  = '0;
          end
        end
      end
      SAMPLE: begin
        if (!start_reg) begin
          state_next = IDLE;
        end else begin
          hits_inc  = data ? (hits_reg + 1'b1) : '0;
          hits_next = hits_inc;
          cnt_next  = cnt_reg + 1'b1;
          if (hits_inc == HIT_MAX) begin
            set_hit    = 1'b1;
            state_next = NEXT;
          end else if (cnt_reg == WIN_END) begin
            state_next = NEXT;
          end
        end
      end
      NEXT: begin
        if (!start_reg) begin
          state_next = IDLE;
        end else begin
          mux_next   = (mux == LAST_CH) ? '0 : (mux + 1'b1);
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fault
    assign fault_set[gi]  = set_hit && (mux == SEL_W'(gi));
    assign fault_clr[gi]  = (wr_fault && bus.writedata[gi]) || (wr_ctrl && bus.writedata[2]);
    // A new detection outranks a clear landing on the same bit.
    assign fault_next[gi] = (fault_reg[gi] & ~fault_clr[gi]) | fault_set[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_reg <= 1'b0;
      force_reg <= 1'b0;
      fault_reg <= '0;
      mask_reg  <= '1;
      kill_sw   <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        start_reg <= bus.writedata[0];
        force_reg <= bus.writedata[1];
      end
      if (wr_mask) begin
        mask_reg <= bus.writedata[NUM_CH-1:0];
      end
      fault_reg <= fault_next;
      kill_sw   <= force_reg | (|(fault_reg & mask_reg));
      error     <= |fault_reg;
    end
  end

`ifdef POWER_MONITOR_IRQ_EN
  logic irq_reg;
  logic irq_clr;
  assign irq_clr = wr_ctrl && bus.writedata[3];
  assign irq     = irq_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= (irq_reg & ~irq_clr) | (|(fault_next & ~fault_reg));
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    case (bus.address)
      2'd0: begin
        rd_word[0] = start_reg;
        rd_word[1] = force_reg;
      end
      2'd1: begin
        rd_word[SEL_W-1:0] = mux;
        rd_word[8]         = busy;
        rd_word[9]         = error;
        rd_word[10]        = kill_sw;
`ifdef POWER_MONITOR_IRQ_EN
        rd_word[11]        = irq_reg;
`endif
      end
      2'd2:    rd_word[NUM_CH-1:0] = fault_reg;
      default: rd_word[NUM_CH-1:0] = mask_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (rd_en) begin
      bus.readdata <= rd_word;
    end
  end

endmodule
